// File: rtl/axi4_lite_master.sv
// axi4_lite_master: turns single read/write commands into AXI4-Lite transactions.
// Only one transaction is in flight at a time. Its response is held on rsp_*
// until the consumer takes it with rsp_ready.
// Optional feature: define AXI_MASTER_TIMEOUT_EN to give up waiting for B/R
// after TIMEOUT_CYCLES. The response then carries SLVERR and rsp_timeout=1.
module axi4_lite_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    DONE
  } state_t;

  state_t              r_state;
  logic                r_cmdReady;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_rspValid;
  logic [1:0]          r_rspResp;
  logic [DATA_W-1:0]   r_rspRdata;
  logic                w_awDone;
  logic                w_wDone;

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  logic [CntW-1:0] r_count;
  logic            r_rspTimeout;
  logic            w_timeUp;
  assign w_timeUp    = (r_count == CntLast);
  assign rsp_timeout = r_rspTimeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  // A channel counts as finished when it was handshaken earlier (VALID
  // already dropped) or when it completes in the current cycle.
  assign w_awDone = ~r_awvalid | AWREADY;
  assign w_wDone  = ~r_wvalid  | WREADY;

  assign cmd_ready = r_cmdReady;
  assign AWADDR    = r_addr;
  assign ARADDR    = r_addr;
  assign WDATA     = r_wdata;
  assign WSTRB     = r_wstrb;
  assign AWVALID   = r_awvalid;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;
  assign rsp_valid = r_rspValid;
  assign rsp_resp  = r_rspResp;
  assign rsp_rdata = r_rspRdata;

  // Transaction sequencer; every handshake output is a register updated here.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= IDLE;
      r_cmdReady <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspResp  <= 2'b00;
      r_rspRdata <= '0;
`ifdef AXI_MASTER_TIMEOUT_EN
      r_count      <= '0;
      r_rspTimeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmdReady) begin
            r_cmdReady <= 1'b0;
            r_addr     <= cmd_addr;
            r_wdata    <= cmd_wdata;
            r_wstrb    <= cmd_wstrb;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end else begin
            r_cmdReady <= 1'b1;
          end
        end
        WR_REQ: begin
          if (r_awvalid && AWREADY) r_awvalid <= 1'b0;
          if (r_wvalid && WREADY) r_wvalid <= 1'b0;
          if (w_awDone && w_wDone) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_count  <= '0;
`endif
          end
        end
        WR_RESP: begin
          if (BVALID) begin
            r_bready   <= 1'b0;
            r_rspResp  <= BRESP;
            r_rspRdata <= '0;
            r_rspValid <= 1'b1;
            r_state    <= DONE;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_rspTimeout <= 1'b0;
          end else if (w_timeUp) begin
            r_bready     <= 1'b0;
            r_rspResp    <= 2'b10;
            r_rspRdata   <= '0;
            r_rspTimeout <= 1'b1;
            r_rspValid   <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
`endif
          end
        end
        RD_REQ: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_RESP;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_count   <= '0;
`endif
          end
        end
        RD_RESP: begin
          if (RVALID) begin
            r_rready   <= 1'b0;
            r_rspResp  <= RRESP;
            r_rspRdata <= RDATA;
            r_rspValid <= 1'b1;
            r_state    <= DONE;
`ifdef AXI_MASTER_TIMEOUT_EN
            r_rspTimeout <= 1'b0;
          end else if (w_timeUp) begin
            r_rready     <= 1'b0;
            r_rspResp    <= 2'b10;
            r_rspRdata   <= '0;
            r_rspTimeout <= 1'b1;
            r_rspValid   <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_count <= r_count + 1'b1;
`endif
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rspValid <= 1'b0;
            r_cmdReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: randomized bench for axi4_lite_master.
// The bench plays a 16-word AXI4-Lite slave. It predicts every response
// from that memory array, and from the delays and response codes it chose.
module tb_axi4_lite_master;

  localparam int AddrW = 32;
  localparam int DataW = 32;
  localparam int TimeoutCycles = 16;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [AddrW-1:0] cmd_addr;
  logic [DataW-1:0] cmd_wdata;
  logic [3:0]       cmd_wstrb;
  logic             rsp_valid, rsp_ready, rsp_timeout;
  logic [DataW-1:0] rsp_rdata;
  logic [1:0]       rsp_resp;
  logic [AddrW-1:0] AWADDR, ARADDR;
  logic             AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic             ARVALID, ARREADY, RVALID, RREADY;
  logic [DataW-1:0] WDATA, RDATA;
  logic [3:0]       WSTRB;
  logic [1:0]       BRESP, RRESP;

  int nCompared = 0;
  int nMismatched = 0;
  logic [31:0] slaveMem [16];

  axi4_lite_master #(
    .ADDR_W(AddrW), .DATA_W(DataW), .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Free-running clock; the bench drives and samples on the falling edge.
  always #5 ACLK = ~ACLK;

  // Count one comparison and report it if observed and expected disagree.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Merge a write into the previous word, one byte lane per strobe bit.
  function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
    return res;
  endfunction

  // Wait, within a bound, until the DUT is ready. Then present one command.
  task automatic sendCommand(input bit isWrite, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge ACLK);
      guard++;
    end
    checkOutput("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = isWrite;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    @(negedge ACLK);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    checkOutput("cmd_ready_busy", cmd_ready, 0);
  endtask

  // Run one complete transaction against the slave model.
  // The AW/AR, W and B/R delays are in cycles. respCode is the slave's BRESP/RRESP.
  // holdCycles keeps rsp_ready low in DONE. abortInResp pulses reset during WR_RESP.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input int delayA, input int delayW, input int respDelay,
                               input logic [1:0] respCode, input int holdCycles,
                               input bit abortInResp);
    int c, aCnt, wCnt, readyCnt, idx;
    bit aDone, wDone, payloadOk, stableOk;
    logic [31:0] expData;
    logic [33:0] snap;
    idx = int'(addr[5:2]);
    sendCommand(isWrite, addr, data, strb);
    aDone = 0; wDone = !isWrite; aCnt = 0; wCnt = 0; c = 0; payloadOk = 1;
    while (!(aDone && wDone) && c < 64) begin
      if (isWrite) begin
        if (AWVALID === 1'b1) begin
          aCnt++;
          if (AWADDR !== addr) payloadOk = 0;
        end
        if (WVALID === 1'b1) begin
          wCnt++;
          if ({WSTRB, WDATA} !== {strb, data}) payloadOk = 0;
        end
        AWREADY = !aDone && c >= delayA;
        WREADY  = !wDone && c >= delayW;
        if (AWREADY && AWVALID === 1'b1) aDone = 1;
        if (WREADY && WVALID === 1'b1) wDone = 1;
      end else begin
        if (ARVALID === 1'b1) begin
          aCnt++;
          if (ARADDR !== addr) payloadOk = 0;
        end
        ARREADY = c >= delayA;
        if (ARREADY && ARVALID === 1'b1) aDone = 1;
      end
      @(negedge ACLK);
      AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
      c++;
    end
    checkOutput("req_handshake_done", {aDone, wDone}, 2'b11);
    checkOutput("req_payload_stable", payloadOk, 1);
    checkOutput("a_valid_cycles", aCnt, delayA + 1);
    if (isWrite) begin
      checkOutput("w_valid_cycles", wCnt, delayW + 1);
      slaveMem[idx] = mergeBytes(slaveMem[idx], data, strb);
    end
    checkOutput("valids_dropped", {AWVALID, WVALID, ARVALID}, 0);

    if (abortInResp) begin
      checkOutput("bready_before_reset", BREADY, 1);
      ARESET = 1'b1;
      @(negedge ACLK);
      checkOutput("reset_outputs", {cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID,
                  BREADY, ARVALID, RREADY, rsp_resp, rsp_rdata}, 0);
      ARESET = 1'b0;
      BVALID = 1'b1;
      BRESP  = 2'b00;
      @(negedge ACLK);
      BVALID = 1'b0;
      checkOutput("after_reset", {rsp_valid, cmd_ready}, 2'b01);
      return;
    end

    readyCnt = 0;
    for (int i = 0; i < respDelay; i++) begin
      if ((isWrite ? BREADY : RREADY) === 1'b1) readyCnt++;
      @(negedge ACLK);
    end
    if ((isWrite ? BREADY : RREADY) === 1'b1) readyCnt++;
    if (isWrite) begin
      BVALID = 1'b1; BRESP = respCode;
      expData = 32'h0;
    end else begin
      RVALID = 1'b1; RRESP = respCode; RDATA = slaveMem[idx];
      expData = slaveMem[idx];
    end
    @(negedge ACLK);
    BVALID = 1'b0; RVALID = 1'b0;
    BRESP = 2'($urandom); RRESP = 2'($urandom); RDATA = $urandom;
    checkOutput("resp_ready_cycles", readyCnt, respDelay + 1);
    checkOutput("rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
                {1'b1, 1'b0, respCode, expData});
    checkOutput("quiet_in_done", {BREADY, RREADY, AWVALID, WVALID, ARVALID, cmd_ready}, 0);

    snap = {rsp_resp, rsp_rdata};
    stableOk = 1;
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge ACLK);
      if ({rsp_valid, cmd_ready} !== 2'b10 || {rsp_resp, rsp_rdata} !== snap) stableOk = 0;
    end
    checkOutput("rsp_hold_stable", stableOk, 1);
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    checkOutput("rsp_released", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // Main sequence: reset, directed cases, random traffic, optional timeout case.
  initial begin
    logic [31:0] rAddr, rData;
    int rc, n;
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    ARREADY = 1'b0; RVALID = 1'b0; RRESP = 2'b00; RDATA = '0;
    for (int i = 0; i < 16; i++) slaveMem[i] = $urandom;

    repeat (3) @(negedge ACLK);
    checkOutput("reset_state", {cmd_ready, rsp_valid, rsp_timeout, AWVALID, WVALID,
                BREADY, ARVALID, RREADY, rsp_resp, rsp_rdata}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("cmd_ready_after_release", cmd_ready, 1);

    applyStimulus(1'b1, 32'h04, 32'h12345678, 4'hF, 0, 0, 0, 2'b00, 0, 1'b0);
    applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 1'b0);
    applyStimulus(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3, 0, 1, 2'b00, 0, 1'b0);
    applyStimulus(1'b1, 32'h0C, 32'hA5A5A5A5, 4'b0101, 0, 2, 0, 2'b10, 0, 1'b0);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 2, 0, 3, 2'b00, 5, 1'b0);
    applyStimulus(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 2'b00, 0, 1'b1);
    applyStimulus(1'b0, 32'h04, 32'h0, 4'h0, 0, 0, 0, 2'b00, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      rAddr = {26'h0, 4'($urandom), 2'b00};
      rData = $urandom;
      applyStimulus(1'($urandom), rAddr, rData, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 2'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    sendCommand(1'b0, 32'h10, 32'h0, 4'h0);
    ARREADY = 1'b1;
    @(negedge ACLK);
    ARREADY = 1'b0;
    rc = 0; n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      if (RREADY === 1'b1) rc++;
      @(negedge ACLK);
      n++;
    end
    checkOutput("timeout_rready_cycles", rc, TimeoutCycles);
    checkOutput("timeout_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata, RREADY},
                {1'b1, 1'b1, 2'b10, 32'h0, 1'b0});
    rsp_ready = 1'b1;
    @(negedge ACLK);
    rsp_ready = 1'b0;
    checkOutput("timeout_released", {rsp_valid, cmd_ready}, 2'b01);
`else
    rc = 0; n = 0;
    checkOutput("timeout_tied_low", rsp_timeout, rc + n);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI data width; WSTRB width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, response-wait limit; used only with AXI_MASTER_TIMEOUT_EN.
REQ-004 SHALL have ports, clock and reset first:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP, or 2'b10 on timeout.
- rsp_timeout  out  1  response produced by timeout; tied 0 without AXI_MASTER_TIMEOUT_EN.
- AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in; BRESP/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out: standard AXI4-Lite master side.

Function
REQ-005 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-006 SHALL assert cmd_ready only in IDLE; command accepted on cmd_valid&&cmd_ready, with addr/wdata/wstrb/write registered that cycle.
REQ-007 On accepted write, SHALL enter WR_REQ next cycle, asserting AWVALID and WVALID together from registered values.
REQ-008 In WR_REQ, SHALL drop AWVALID the cycle after AW handshake and WVALID the cycle after W handshake, independently; SHALL enter WR_RESP once both handshakes are done, including same-cycle completion.
REQ-009 SHALL hold AWVALID/WVALID and their payloads stable until handshake; SHALL not wait on AWREADY/WREADY before asserting VALID.
REQ-010 In WR_RESP, SHALL drive BREADY=1; on BVALID capture BRESP into rsp_resp, set rsp_rdata=0, and enter DONE.
REQ-011 On accepted read, SHALL enter RD_REQ asserting ARVALID with ARADDR stable until ARREADY; then enter RD_RESP.
REQ-012 In RD_RESP, SHALL drive RREADY=1; on RVALID capture RDATA/RRESP and enter DONE.
REQ-013 In DONE, SHALL hold rsp_valid=1 with stable rsp_* until rsp_ready, then return to IDLE; minimum command-to-command spacing is 1 IDLE cycle.
REQ-014 SHALL keep exactly one transaction outstanding; no AXI VALID asserted outside WR_REQ/RD_REQ.
REQ-015 BREADY/RREADY SHALL be high only in WR_RESP/RD_RESP respectively.

Reset
REQ-016 With ARESET high at a rising edge, SHALL go to IDLE and clear all VALID/READY outputs, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata and timeout counter to 0; cmd_ready rises the cycle after ARESET falls.
REQ-017 Reset mid-transaction SHALL abandon it silently; no rsp_valid for the abandoned command.

Configuration
REQ-018 With macro AXI_MASTER_TIMEOUT_EN defined, SHALL count cycles in WR_RESP/RD_RESP; when the count reaches TIMEOUT_CYCLES without BVALID/RVALID, SHALL drop BREADY/RREADY, enter DONE with rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1; counter clears on entry to either state; a response arriving on the limit cycle wins over timeout.
REQ-019 Without AXI_MASTER_TIMEOUT_EN, SHALL have no counter, wait indefinitely, and tie rsp_timeout=0.

Verification
REQ-020 Write addr 0x04 data 0x12345678 strb 0xF, slave ready immediately -> AW/W single-cycle handshake, BRESP 0, rsp_valid with rsp_resp=0, rsp_rdata=0.
REQ-021 Read 0x04 after REQ-020 -> ARVALID until ARREADY; rsp_rdata=0x12345678, rsp_resp=0.
REQ-022 Write with AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after 1 cycle, AWVALID held 4 cycles, single B handshake.
REQ-023 rsp_ready held low 5 cycles in DONE -> rsp_valid and rsp_* stable, cmd_ready low throughout.
REQ-024 ARESET pulsed during WR_RESP -> all outputs 0 next cycle, no rsp_valid, next read 0x04 completes normally.
REQ-025 With AXI_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, read with RVALID never asserted -> after 16 RD_RESP cycles rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1, RREADY=0.
